lr_car_detector: RTL and testbench



---
 rtl/lr_car_detector_if.sv | 21 ++
 rtl/lr_car_detector.sv | 140 ++++++++++++++
 tb/tb_lr_car_detector.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/lr_car_detector_if.sv
// Signal bundle between the local-road sensor front end and the traffic light controller.
// The master drives sensor/light; the slave (the detector) returns the debounced queue state.
interface lr_car_detector_if #(
  parameter int CNT_W = 4
);
  logic             lr_sensor_raw;
  logic [2:0]       lr_light;
  logic             lr_has_car;
  logic [CNT_W-1:0] car_count;
  logic             overflow;

  modport master (
    output lr_sensor_raw, lr_light,
    input  lr_has_car, car_count, overflow
  );

  modport slave (
    input  lr_sensor_raw, lr_light,
    output lr_has_car, car_count, overflow
  );
endinterface

// File: rtl/lr_car_detector.sv
// Local-road car detector: synchronises and debounces the loop sensor, queues arrivals,
// and retires one queued car per DEPART_CYCLES clocks of local-road green.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | sensor low and settled, waiting for a rising edge
// RISE_CHK | sensor high, confirming it stays high for DEB_CYCLES
// PRESENT  | car present and already counted
// FALL_CHK | sensor low, confirming release before re-arming
module lr_car_detector #(
  parameter int DEB_CYCLES    = 4,
  parameter int DEPART_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  lr_car_detector_if.slave bus
);
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int DEP_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [2:0] LIGHT_GREEN = 3'b100;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RISE_CHK = 2'd1,
    PRESENT  = 2'd2,
    FALL_CHK = 2'd3
  } deb_state_e;

  logic             s1_q, s2_q;
  deb_state_e       state_q, state_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [DEP_W-1:0] dep_cnt_q, dep_cnt_d;
  logic [CNT_W-1:0] car_count_q, car_count_d;
  logic             overflow_q, overflow_d;

  logic sync;
  logic deb_last;
  logic arrival;
  logic dep_run;
  logic dep_last;
  logic departure;
  logic full;

  assign sync     = s2_q;
  assign deb_last = (deb_cnt_q == DEB_W'(DEB_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      dep_cnt_q   <= '0;
      car_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      s1_q        <= bus.lr_sensor_raw;
      s2_q        <= s1_q;
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      dep_cnt_q   <= dep_cnt_d;
      car_count_q <= car_count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Arrival fires on the transition into PRESENT, so a parked car counts only once.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    arrival   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync) begin
          state_d   = RISE_CHK;
          deb_cnt_d = '0;
        end
      end
      RISE_CHK: begin
        if (!sync) begin
          state_d = IDLE;
        end else if (deb_last) begin
          state_d = PRESENT;
          arrival = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      PRESENT: begin
        if (!sync) begin
          state_d   = FALL_CHK;
          deb_cnt_d = '0;
        end
      end
      FALL_CHK: begin
        if (sync) begin
          state_d = PRESENT;
        end else if (deb_last) begin
          state_d = IDLE;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer only runs on a clean green with cars waiting; anything else restarts the spacing.
  assign dep_run   = (bus.lr_light == LIGHT_GREEN) && (car_count_q != '0);
  assign dep_last  = (dep_cnt_q == DEP_W'(DEPART_CYCLES - 1));
  assign departure = dep_run && dep_last;

  always_comb begin
    dep_cnt_d = '0;
    if (dep_run && !dep_last) begin
      dep_cnt_d = dep_cnt_q + 1'b1;
    end
  end

  assign full = &car_count_q;

  always_comb begin
    car_count_d = car_count_q;
    overflow_d  = overflow_q;
    if (arrival && !departure) begin
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        car_count_d = car_count_q + 1'b1;
      end
    end else if (departure && !arrival) begin
      car_count_d = car_count_q - 1'b1;
    end
  end

  assign bus.car_count  = car_count_q;
  assign bus.lr_has_car = (car_count_q != '0);
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_lr_car_detector.sv
// Directed bench for lr_car_detector: arrival latency, glitch rejection, departure spacing,
// saturation/overflow and asynchronous reset, all against hand-computed values.
module tb_lr_car_detector;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  lr_car_detector_if #(.CNT_W(4)) bus ();

  lr_car_detector #(
    .DEB_CYCLES   (4),
    .DEPART_CYCLES(8),
    .CNT_W        (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.lr_sensor_raw = 1'b0;
    bus.lr_light      = 3'b001;
    rst_n             = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic add_cars(input int n);
    for (int i = 0; i < n; i++) begin
      bus.lr_sensor_raw = 1'b1;
      step(10);
      bus.lr_sensor_raw = 1'b0;
      step(10);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.lr_sensor_raw = 1'b0;
    bus.lr_light      = 3'b001;
    #3;

    // 1: reset values, then a held sensor gives exactly one arrival on edge 7
    do_reset();
    chk("rst_count", 8'(bus.car_count), 8'd0);
    chk("rst_has_car", 8'(bus.lr_has_car), 8'd0);
    chk("rst_overflow", 8'(bus.overflow), 8'd0);
    bus.lr_sensor_raw = 1'b1;
    step(6);
    chk("latency_e6", 8'(bus.car_count), 8'd0);
    step(1);
    chk("latency_e7", 8'(bus.car_count), 8'd1);
    chk("latency_has_car", 8'(bus.lr_has_car), 8'd1);
    step(13);
    chk("held_once", 8'(bus.car_count), 8'd1);
    bus.lr_sensor_raw = 1'b0;
    step(10);

    // 2: bouncing sensor, high for only 2 sync samples at a time
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus.lr_sensor_raw = ~bus.lr_sensor_raw;
      step(2);
    end
    bus.lr_sensor_raw = 1'b0;
    step(10);
    chk("bounce_count", 8'(bus.car_count), 8'd0);

    // 3: three cars retired at green edges 8, 16, 24
    do_reset();
    add_cars(3);
    chk("three_cars", 8'(bus.car_count), 8'd3);
    bus.lr_light = 3'b100;
    step(7);
    chk("green_e7", 8'(bus.car_count), 8'd3);
    step(1);
    chk("green_e8", 8'(bus.car_count), 8'd2);
    step(7);
    chk("green_e15", 8'(bus.car_count), 8'd2);
    step(1);
    chk("green_e16", 8'(bus.car_count), 8'd1);
    step(7);
    chk("green_e23_has_car", 8'(bus.lr_has_car), 8'd1);
    step(1);
    chk("green_e24", 8'(bus.car_count), 8'd0);
    chk("green_e24_has_car", 8'(bus.lr_has_car), 8'd0);
    step(6);
    chk("dep_cnt_idle", 8'(dut.dep_cnt_q), 8'd0);
    bus.lr_light = 3'b001;

    // 4: interrupted green restarts the departure spacing; illegal light codes never depart
    do_reset();
    add_cars(2);
    bus.lr_light = 3'b100;
    step(5);
    chk("green5_count", 8'(bus.car_count), 8'd2);
    bus.lr_light = 3'b001;
    step(3);
    bus.lr_light = 3'b100;
    step(7);
    chk("regreen_e7", 8'(bus.car_count), 8'd2);
    step(1);
    chk("regreen_e8", 8'(bus.car_count), 8'd1);
    bus.lr_light = 3'b110;
    step(20);
    chk("illegal_light", 8'(bus.car_count), 8'd1);
    bus.lr_light = 3'b001;

    // 5: fill to 15, coincident arrival+departure, then overflow
    do_reset();
    add_cars(15);
    chk("full_count", 8'(bus.car_count), 8'd15);
    chk("full_no_ovf", 8'(bus.overflow), 8'd0);
    bus.lr_light = 3'b100;
    step(1);
    bus.lr_sensor_raw = 1'b1;
    step(6);
    chk("coinc_before", 8'(bus.car_count), 8'd15);
    step(1);
    chk("coinc_count", 8'(bus.car_count), 8'd15);
    chk("coinc_ovf", 8'(bus.overflow), 8'd0);
    bus.lr_light      = 3'b001;
    bus.lr_sensor_raw = 1'b0;
    step(10);
    bus.lr_sensor_raw = 1'b1;
    step(10);
    chk("ovf_count", 8'(bus.car_count), 8'd15);
    chk("ovf_flag", 8'(bus.overflow), 8'd1);
    bus.lr_sensor_raw = 1'b0;
    step(10);
    chk("ovf_sticky", 8'(bus.overflow), 8'd1);

    // 6: asynchronous reset mid-debounce with a non-empty queue
    do_reset();
    add_cars(5);
    bus.lr_sensor_raw = 1'b1;
    step(4);
    chk("pre_rst_count", 8'(bus.car_count), 8'd5);
    rst_n = 1'b0;
    #2;
    chk("async_rst_count", 8'(bus.car_count), 8'd0);
    chk("async_rst_has_car", 8'(bus.lr_has_car), 8'd0);
    chk("async_rst_ovf", 8'(bus.overflow), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(6);
    chk("post_rst_e6", 8'(bus.car_count), 8'd0);
    step(1);
    chk("post_rst_e7", 8'(bus.car_count), 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
